// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_rr_arbiter_if.sv
// AXI4-Lite bundle with N parallel ports. The arbiter takes an N=NUM_M copy
// through the slave modport (facing the masters) and an N=1 copy through the
// master modport (facing the single downstream slave).
interface axi4_lite_rr_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [N-1:0][ADDR_W-1:0] araddr;
  logic [N-1:0]             arvalid;
  logic [N-1:0]             arready;
  logic [N-1:0][DATA_W-1:0] rdata;
  logic [N-1:0][1:0]        rresp;
  logic [N-1:0]             rvalid;
  logic [N-1:0]             rready;
  logic [N-1:0][ADDR_W-1:0] awaddr;
  logic [N-1:0]             awvalid;
  logic [N-1:0]             awready;
  logic [N-1:0][DATA_W-1:0] wdata;
  logic [N-1:0][STRB_W-1:0] wstrb;
  logic [N-1:0]             wvalid;
  logic [N-1:0]             wready;
  logic [N-1:0][1:0]        bresp;
  logic [N-1:0]             bvalid;
  logic [N-1:0]             bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/rr_pick.sv
// Request selector: round-robin starting one past ptr, or fixed priority
// (lowest index wins) when AXI_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int NUM_M = 2,
  parameter int PTR_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest requesting index is the last writer
  always_comb begin
    logic [PTR_W-1:0] idx;
    gnt = '0;
    idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      idx = PTR_W'(i);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
`else
  // Search from (ptr+1) mod NUM_M and take the first requester found
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_M);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/axi4_lite_rr_arbiter.sv
// AXI4-Lite N:1 arbiter with independent read and write paths. Each path
// latches a grant when it leaves IDLE and holds it until its response
// completes. Define AXI_ARB_FIXED_PRIO_EN for fixed priority instead of
// round-robin.
module axi4_lite_rr_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi4_lite_rr_arbiter_if.slave  m,
  axi4_lite_rr_arbiter_if.master s,
  output logic [NUM_M-1:0]       rd_gnt,
  output logic [NUM_M-1:0]       wr_gnt
);

  localparam int               PTR_W   = $clog2(NUM_M);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_M - 1);

  rd_state_t        rd_state_q, rd_state_d;
  wr_state_t        wr_state_q, wr_state_d;
  logic [NUM_M-1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NUM_M-1:0] rd_pick, wr_pick, wr_req;
  logic [PTR_W-1:0] rd_pick_idx, wr_pick_idx;
  logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign wr_req = m.awvalid | m.wvalid;
  assign ar_hs  = s.arvalid[0] & s.arready[0];
  assign r_hs   = s.rvalid[0]  & s.rready[0];
  assign aw_hs  = s.awvalid[0] & s.awready[0];
  assign w_hs   = s.wvalid[0]  & s.wready[0];
  assign b_hs   = s.bvalid[0]  & s.bready[0];
  assign rd_gnt = rd_gnt_q;
  assign wr_gnt = wr_gnt_q;

  rr_pick #(.NUM_M(NUM_M), .PTR_W(PTR_W)) u_rd_pick (
    .req (m.arvalid),
    .ptr (rd_ptr_q),
    .gnt (rd_pick)
  );

  rr_pick #(.NUM_M(NUM_M), .PTR_W(PTR_W)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr_q),
    .gnt (wr_pick)
  );

  // Encode the one-hot picks into indices for the last-grant pointers
  always_comb begin
    rd_pick_idx = '0;
    wr_pick_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (rd_pick[i]) rd_pick_idx = PTR_W'(i);
      if (wr_pick[i]) wr_pick_idx = PTR_W'(i);
    end
  end

  // Read path state, grant and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= '0;
      rd_ptr_q   <= PTR_RST;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Read FSM: grant on IDLE exit, then address phase, then response phase
  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      R_IDLE: if (|m.arvalid) begin
        rd_state_d = R_ADDR;
        rd_gnt_d   = rd_pick;
        rd_ptr_d   = rd_pick_idx;
      end
      R_ADDR: if (ar_hs) rd_state_d = R_RESP;
      R_RESP: if (r_hs) begin
        rd_state_d = R_IDLE;
        rd_gnt_d   = '0;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Route AR/R between the granted master and the slave; others see zeros
  always_comb begin
    m.arready    = '0;
    m.rvalid     = '0;
    m.rdata      = '0;
    m.rresp      = {NUM_M{RESP_OKAY}};
    s.arvalid    = 1'b0;
    s.araddr[0]  = ADDR_W'(0);
    s.rready     = 1'b0;
    case (rd_state_q)
      R_ADDR: begin
        s.arvalid          = m.arvalid[rd_ptr_q];
        s.araddr[0]        = m.araddr[rd_ptr_q];
        m.arready[rd_ptr_q] = s.arready[0];
      end
      R_RESP: begin
        s.rready           = m.rready[rd_ptr_q];
        m.rvalid[rd_ptr_q] = s.rvalid[0];
        m.rdata[rd_ptr_q]  = s.rdata[0];
        m.rresp[rd_ptr_q]  = s.rresp[0];
      end
      default: ;
    endcase
  end

  // Write path state, grant, pointer and channel-done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= '0;
      wr_ptr_q   <= PTR_RST;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Write FSM: AW and W may finish in either order; RESP once both are done
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: if (|wr_req) begin
        wr_state_d = W_DATA;
        wr_gnt_d   = wr_pick;
        wr_ptr_d   = wr_pick_idx;
      end
      W_DATA: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_RESP: if (b_hs) begin
        wr_state_d = W_IDLE;
        wr_gnt_d   = '0;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Route AW/W/B between the granted master and the slave; a finished channel is not re-forwarded
  always_comb begin
    m.awready   = '0;
    m.wready    = '0;
    m.bvalid    = '0;
    m.bresp     = {NUM_M{RESP_OKAY}};
    s.awvalid   = 1'b0;
    s.awaddr[0] = ADDR_W'(0);
    s.wvalid    = 1'b0;
    s.wdata[0]  = DATA_W'(0);
    s.wstrb[0]  = '0;
    s.bready    = 1'b0;
    case (wr_state_q)
      W_DATA: begin
        if (!aw_done_q) begin
          s.awvalid           = m.awvalid[wr_ptr_q];
          s.awaddr[0]         = m.awaddr[wr_ptr_q];
          m.awready[wr_ptr_q] = s.awready[0];
        end
        if (!w_done_q) begin
          s.wvalid           = m.wvalid[wr_ptr_q];
          s.wdata[0]         = m.wdata[wr_ptr_q];
          s.wstrb[0]         = m.wstrb[wr_ptr_q];
          m.wready[wr_ptr_q] = s.wready[0];
        end
      end
      W_RESP: begin
        s.bready           = m.bready[wr_ptr_q];
        m.bvalid[wr_ptr_q] = s.bvalid[0];
        m.bresp[wr_ptr_q]  = s.bresp[0];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi4_lite_rr_arbiter.md
AXI4_LITE_RR_ARBITER -- requirements
Module: axi4_lite_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2, number of AXI4-Lite masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have master AR ports m_araddr input NUM_M x ADDR_W, m_arvalid input NUM_M, and m_arready output NUM_M.
REQ-007 SHALL have master R ports m_rdata output NUM_M x DATA_W, m_rresp output NUM_M x 2, m_rvalid output NUM_M, and m_rready input NUM_M.
REQ-008 SHALL have master AW/W ports m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, and m_wready, with widths as for AR.
REQ-009 SHALL have master B ports m_bresp output NUM_M x 2, m_bvalid output NUM_M, and m_bready input NUM_M.
REQ-010 SHALL have slave ports s_ar*, s_r*, s_aw*, s_w*, and s_b*, one single-width copy of each master signal with direction reversed.
REQ-011 SHALL have ports rd_gnt and wr_gnt, each output NUM_M, giving the one-hot current read/write grant (all-zero when idle).

Function
REQ-012 SHALL arbitrate the read path (AR/R) and write path (AW/W/B) independently, so one read and one write can be in flight concurrently to different or the same master.
REQ-013 SHALL run each read FSM as: IDLE -> ADDR when any m_arvalid; ADDR -> RESP on the s_arvalid&s_arready handshake; RESP -> IDLE on the s_rvalid&s_rready handshake.
REQ-014 SHALL run each write FSM as: IDLE -> DATA when any m_awvalid|m_wvalid; DATA -> RESP once both the AW and W handshakes have completed, in either order or in the same cycle; RESP -> IDLE on the s_bvalid&s_bready handshake.
REQ-015 SHALL register the grant on the IDLE exit and hold it unchanged until the FSM returns to IDLE, so latency is 1 cycle from request to the first s_*valid.
REQ-016 SHALL gate all s_*valid outputs by the FSM state: s_arvalid only in ADDR, s_awvalid only in DATA with aw_done=0, and s_wvalid only in DATA with w_done=0.
REQ-017 SHALL, in DATA, set aw_done on the AW handshake and w_done on the W handshake, never re-forward a completed channel, and clear both flags on entry to RESP.
REQ-018 SHALL route ready, R, and B signals to the granted master only; every non-granted master sees valid=0 and ready=0, with data driven to 0.
REQ-019 SHALL drive s_rready and s_bready only in RESP, from the granted master's m_rready and m_bready.
REQ-020 SHALL use a round-robin selection that searches from index (last_grant+1) mod NUM_M and updates last_grant only on the IDLE exit.
REQ-021 SHALL keep separate read and write last_grant pointers, each of width $clog2(NUM_M).
REQ-022 SHALL ignore any new request arriving while the FSM is not IDLE until the FSM next returns to IDLE, with no request lost while m_*valid stays asserted.
REQ-023 SHALL, when the response handshake and a new request occur in the same cycle, return to IDLE and grant in the following cycle, giving exactly 1 bubble cycle.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force both FSMs to IDLE, both pointers to NUM_M-1 (so index 0 is searched first), and aw_done=w_done=0.
REQ-025 SHALL force every valid/ready output to 0 and rd_gnt=wr_gnt=0 while rst_n is low, including when reset is asserted mid-transaction.
REQ-026 SHALL not replay an in-flight transaction aborted by reset; slave-side cleanup is not this block's duty.

Configuration
REQ-027 SHALL, when AXI_ARB_FIXED_PRIO_EN is defined, replace round-robin with fixed priority (lowest index wins) and leave the pointers unused.
REQ-028 SHALL use round-robin per REQ-020 when AXI_ARB_FIXED_PRIO_EN is undefined.

Structure
REQ-029 SHALL place the typedefs rd_state_t {R_IDLE,R_ADDR,R_RESP} and wr_state_t {W_IDLE,W_DATA,W_RESP} and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 in the shared package axi4_lite_pkg.
REQ-030 SHALL implement selection in the sub-module rr_pick (inputs req[NUM_M] and ptr; output one-hot gnt), instantiated once for read and once for write.

Verification
REQ-031 SHALL cover: NUM_M=2 with m_arvalid=2'b11 from reset -> grants m0, then m1, then m0 on successive reads, with s_arvalid 1 cycle after each IDLE.
REQ-032 SHALL cover: m0 read and m1 write issued in the same cycle -> rd_gnt=01 and wr_gnt=10 together, and both complete with no interference.
REQ-033 SHALL cover: m1 W handshake 3 cycles before AW -> a single s_wvalid pulse, no re-forward, and RESP entered the cycle after AW.
REQ-034 SHALL cover: NUM_M=4 with all masters requesting reads continuously -> grant order 0,1,2,3,0, and m_rvalid asserts only on the granted index.
REQ-035 SHALL cover: rst_n pulled low in W_RESP with s_bvalid=1 -> all outputs 0 immediately, and the next request after release is granted to m0.
REQ-036 SHALL cover: AXI_ARB_FIXED_PRIO_EN defined with m0 and m2 requesting continuously -> m2 never granted while m0 requests.
